// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word skid buffer; first bit on x one clk after accept.
// din_ready drops only while the skid buffer is occupied; back-to-back words stream without gaps.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;
  logic             last_bit;

  // Ready depends only on the buffer flag register, never on din_valid.
  assign accept   = din_valid && !hold_full;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            // Refill from the buffer first, else bypass a fresh word, else go idle.
            cnt <= '0;
            if (hold_full) begin
              sreg      <= hold;
              hold_full <= 1'b0;
            end else if (accept) begin
              sreg <= din;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (MSB_FIRST)
              sreg <= {sreg[WIDTH-2:0], 1'b0};
            else
              sreg <= {1'b0, sreg[WIDTH-1:1]};
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign din_ready = !hold_full;
  assign x_valid   = (state == SHIFT);
  assign word_done = last_bit;
  assign x         = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and are
// checked against a pending-bit / expected-bit-queue model of the serial stream.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, x, x_valid, word_done;
  logic         rdy_l, x_l, xv_l, wd_l;

  int total = 0;
  int bad   = 0;

  // Model state: bits still owed on the wire, and the expected bit order per instance.
  int   pending = 0;
  logic qm[$];
  logic ql[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         ex;
    logic         exv;
    logic         ewd;
    logic         erdy;
  } vec_t;
  vec_t tbl[$];

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .word_done(word_done)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .word_done(wd_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [W-1:0] d, input logic ex,
                              input logic exv, input logic ewd, input logic erdy);
    vec_t r;
    r.v = v; r.d = d; r.ex = ex; r.exv = exv; r.ewd = ewd; r.erdy = erdy;
    tbl.push_back(r);
  endfunction

  // One clock cycle: drive, check both instances against the model, then advance the model.
  task automatic cyc(input logic v, input logic [W-1:0] d, output logic acc);
    logic busy;
    din_valid = v;
    din       = d;
    #1;
    busy = (pending > 0);
    chk("ready", din_ready, pending <= W);
    chk("ready_lsb", rdy_l, pending <= W);
    chk("x_valid", x_valid, busy);
    chk("x_valid_lsb", xv_l, busy);
    chk("word_done", word_done, busy && (pending % W == 1));
    chk("word_done_lsb", wd_l, busy && (pending % W == 1));
    if (busy) begin
      chk("x", x, qm[0]);
      chk("x_lsb", x_l, ql[0]);
    end else begin
      chk("x_idle", x, 1'b0);
      chk("x_idle_lsb", x_l, 1'b0);
    end
    acc = v && (pending <= W);
    @(posedge clk);
    if (busy) begin
      pending--;
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc) begin
      pending += W;
      for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
      for (int i = 0; i < W; i++) ql.push_back(d[i]);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, a);
  endtask

  // Hold a word on din until it is taken, with a bounded wait.
  task automatic offer(input logic [W-1:0] d);
    logic a;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 40) begin
      cyc(1'b1, d, a);
      tries++;
    end
    total++;
    if (!a) begin
      bad++;
      $display("FAIL offer_timeout: word %h not accepted after %0d cycles, want accept", d, tries);
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_x", x, 1'b0);
    chk("rst_x_valid", x_valid, 1'b0);
    chk("rst_word_done", word_done, 1'b0);
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_x_valid_lsb", xv_l, 1'b0);
    chk("rst_ready_lsb", rdy_l, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    pending = 0;
    qm.delete();
    ql.delete();
  endtask

  initial begin
    logic [W-1:0] pa, pb, hd;
    logic [W-1:0] exp_l;
    logic         a, hv;

    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;

    // Expected cycle-by-cycle behaviour for a single word and for a buffered pair.
    pa = 8'hB0;
    pb = 8'hDB;
    add(1'b1, pa, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) add(1'b0, '0, pa[W-1-i], 1'b1, i == W - 1, 1'b1);
    add(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, pa, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) add(1'b1, pb, pa[W-1-i], 1'b1, i == W - 1, i == 0);
    for (int i = 0; i < W; i++) add(1'b0, '0, pb[W-1-i], 1'b1, i == W - 1, 1'b1);
    add(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    do_reset();

    foreach (tbl[k]) begin
      din_valid = tbl[k].v;
      din       = tbl[k].d;
      #1;
      chk("tbl_x", x, tbl[k].ex);
      chk("tbl_x_valid", x_valid, tbl[k].exv);
      chk("tbl_word_done", word_done, tbl[k].ewd);
      chk("tbl_ready", din_ready, tbl[k].erdy);
      cyc(tbl[k].v, tbl[k].d, a);
    end

    // Bypass: next word appears only during the last bit with the buffer empty.
    cyc(1'b1, 8'hB0, a);
    idle(W - 1);
    #1;
    chk("bypass_word_done", word_done, 1'b1);
    chk("bypass_ready", din_ready, 1'b1);
    cyc(1'b1, 8'hDB, a);
    #1;
    chk("bypass_no_gap", x_valid, 1'b1);
    chk("bypass_first_bit", x, 1'b1);
    idle(W + 2);

    // Reset mid-word with a word parked in the buffer.
    cyc(1'b1, 8'hB0, a);
    cyc(1'b1, 8'hDB, a);
    cyc(1'b1, 8'hDB, a);
    #1;
    chk("pre_rst_ready_low", din_ready, 1'b0);
    chk("pre_rst_x_valid", x_valid, 1'b1);
    do_reset();
    idle(2 * W + 2);

    // LSB-first ordering of 8'h0D.
    exp_l = 8'b1011_0000;
    cyc(1'b1, 8'h0D, a);
    for (int i = 0; i < W; i++) begin
      #1;
      chk("lsb_0D_bit", x_l, exp_l[W-1-i]);
      cyc(1'b0, '0, a);
    end

    // Third word offered while the buffer is full.
    idle(2);
    offer(8'hB0);
    offer(8'hDB);
    offer(8'h5A);
    idle(3 * W + 2);

    // Random traffic; the source holds a refused word until it is taken.
    hv = 1'b0;
    hd = '0;
    for (int n = 0; n < 500; n++) begin
      logic v;
      logic [W-1:0] d;
      if (hv) begin
        v = 1'b1;
        d = hd;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end
      cyc(v, d, a);
      hv = v && !a;
      hd = d;
    end
    idle(3 * W);

    total++;
    if (pending != 0 || qm.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d queued=%0d want 0", pending, qm.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = shift out bit WIDTH-1 first, 0 = shift out bit 0 first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, giving the value driven on x when no word is being shifted.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din holds a word to transfer.
REQ-008 The block SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 The block SHALL have port x, output, 1 bit: the serial bit stream, one bit per clk, fed directly to the sequence detector input.
REQ-010 The block SHALL have port x_valid, output, 1 bit: x carries a data bit this cycle.
REQ-011 The block SHALL have port word_done, output, 1 bit: a one-cycle pulse coinciding with the last bit of each word on x.

Function
REQ-012 The block SHALL accept a word on a rising edge where din_valid=1 and din_ready=1; no other condition SHALL transfer a word.
REQ-013 The block SHALL hold internal state: FSM {IDLE, SHIFT}, WIDTH-bit shift register, bit counter of width clog2(WIDTH), one-word holding buffer with a full flag.
REQ-014 din_ready SHALL equal NOT buffer_full, taken from a register with no combinational path from din_valid.
REQ-015 IDLE with a word accepted: the word SHALL load into the shift register, counter := 0, FSM := SHIFT; its first bit appears on x the next cycle (latency 1 clk).
REQ-016 SHIFT: x SHALL be shift-register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), with x_valid=1; each edge shifts by one bit toward that end and increments the counter.
REQ-017 Not in SHIFT: x SHALL equal IDLE_BIT and x_valid=0.
REQ-018 word_done SHALL be 1 exactly when FSM=SHIFT and counter=WIDTH-1.
REQ-019 A word accepted in SHIFT while the counter is not WIDTH-1 SHALL be written to the holding buffer, with buffer_full := 1.
REQ-020 At the edge ending the last bit (counter=WIDTH-1) with buffer_full=1: the buffer SHALL load into the shift register, buffer_full := 0, counter := 0, FSM stays SHIFT, leaving no idle cycle on x_valid.
REQ-021 At that edge with buffer_full=0 and a simultaneous accept: din SHALL load directly into the shift register (bypass), FSM stays SHIFT, with no gap.
REQ-022 At that edge with buffer_full=0 and no accept: FSM SHALL go to IDLE.
REQ-023 A word SHALL never be dropped or duplicated; while din_ready=0, din and din_valid are held by the source and ignored by the block.
REQ-024 In a gapless stream, bits of consecutive words SHALL be contiguous in acceptance order.

Reset
REQ-025 While reset=1, asynchronously: FSM := IDLE, shift register := 0, counter := 0, buffer := 0, buffer_full := 0.
REQ-026 While reset=1: x = IDLE_BIT, x_valid = 0, word_done = 0, din_ready = 1.
REQ-027 Reset asserted mid-word SHALL discard the partial word and any buffered word; after release, operation resumes from IDLE on the first accept.

Verification
REQ-028 Reset, then din=8'hB0 with din_valid for 1 cycle -> x = 1,0,1,1,0,0,0,0 on the 8 cycles after the accept, x_valid=1 for exactly those 8 cycles, word_done on the 8th; the downstream detector output y = 1 on the 4th bit.
REQ-029 din_valid held high with 8'hB0 then 8'hDB -> second word buffered on the cycle after the first accept, din_ready=0 until the buffer drains, 16 contiguous x_valid cycles giving x = 10110000 11011011.
REQ-030 Second word presented only in the first word's last-bit cycle with the buffer empty -> bypass accept, din_ready stays 1, no x_valid gap.
REQ-031 reset pulsed after 3 bits of 8'hB0 with a word buffered -> x_valid=0 and x=0 immediately without waiting for clk, din_ready=1, and no remaining bits are emitted after release.
REQ-032 MSB_FIRST=0, din=8'h0D -> x = 1,0,1,1,0,0,0,0.
REQ-033 Third word offered while the buffer is full -> not accepted until din_ready=1; all three words emitted once, in order.
